// File: rtl/ipf_wb_packer.sv
// ipf_wb_packer: packs the IPF per-pixel output stream into 32-bit words
// with byte enables. The words are queued in a FIFO and drained to frame
// memory over a req/ack handshake. The IPF cannot be stalled, so a word that
// arrives at a full FIFO is dropped and overflow is raised (sticky).
// Optional build macro IPF_WB_STATS_EN adds a saturating accepted-word
// counter on output word_cnt.
module ipf_wb_packer #(
    parameter int FIFO_DEPTH = 8
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        in_en,
    input  logic [7:0]  din,
    input  logic [13:0] din_addr,
    input  logic        in_finish,
    output logic        wr_req,
    output logic [11:0] wr_addr,
    output logic [31:0] wr_data,
    output logic [3:0]  wr_be,
    input  logic        wr_ack,
    output logic        overflow,
    output logic        done
`ifdef IPF_WB_STATS_EN
    ,
    output logic [15:0] word_cnt
`endif
);

    localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CW = AW + 1;

    typedef enum logic [1:0] {S_RUN, S_FLUSH, S_DONE} state_t;

    state_t      state;
    logic [11:0] pk_addr;
    logic [31:0] pk_data;
    logic [3:0]  pk_be;
    logic        pk_valid;
    logic        pk_full;
    logic [1:0]  hi_lane;
    logic [1:0]  pix_lane;
    logic [11:0] pix_word;
    logic        take;
    logic        belongs;
    logic        push;
    logic        pop;
    logic        fifo_full;
    logic        push_ok;
    logic [47:0] mem [FIFO_DEPTH];
    logic [47:0] head;
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [CW-1:0] count;

    assign pix_lane = din_addr[1:0];
    assign pix_word = din_addr[13:2];
    assign take     = (state == S_RUN) && in_en;

    // Highest lane already written into the pack; lanes must ascend to merge.
    always_comb begin
        hi_lane = 2'd0;
        for (int k = 0; k < 4; k++)
            if (pk_be[k]) hi_lane = 2'(k);
    end

    assign belongs = pk_valid && !pk_full && (pix_word == pk_addr) && (pix_lane > hi_lane);

    // RUN pushes a full pack, or one closed by a non-belonging pixel;
    // FLUSH pushes whatever pack is left, exactly once.
    always_comb begin
        push = 1'b0;
        if (state == S_RUN)
            push = pk_full || (in_en && pk_valid && !belongs);
        else if (state == S_FLUSH)
            push = pk_valid;
    end

    // Pack register: merge into the open word or start a new one.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pk_addr  <= '0;
            pk_data  <= '0;
            pk_be    <= '0;
            pk_valid <= 1'b0;
            pk_full  <= 1'b0;
        end else if (take) begin
            if (belongs) begin
                pk_data[{pix_lane, 3'b000} +: 8] <= din;
                pk_be[pix_lane]                  <= 1'b1;
            end else begin
                pk_addr  <= pix_word;
                pk_data  <= 32'(din) << {pix_lane, 3'b000};
                pk_be    <= 4'b0001 << pix_lane;
                pk_valid <= 1'b1;
            end
            pk_full <= (pix_lane == 2'd3);
        end else if (push) begin
            pk_valid <= 1'b0;
            pk_full  <= 1'b0;
        end
    end

    // Control FSM; done is registered and never drops until reset.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= S_RUN;
            done  <= 1'b0;
        end else begin
            case (state)
                S_RUN:
                    if (in_finish) state <= S_FLUSH;
                S_FLUSH:
                    if (!pk_valid && (count == '0)) begin
                        state <= S_DONE;
                        done  <= 1'b1;
                    end
                default: done <= 1'b1;
            endcase
        end
    end

    assign fifo_full = (count == CW'(FIFO_DEPTH));
    assign pop       = wr_req && wr_ack;
    // A pop frees the slot in the same edge, so full+pop still accepts.
    assign push_ok   = push && (!fifo_full || pop);

    // FIFO storage; contents are never observed while empty, so no reset.
    always_ff @(posedge clk) begin
        if (push_ok) mem[wr_ptr] <= {pk_addr, pk_data, pk_be};
    end

    // FIFO pointers, occupancy and the sticky drop flag.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + 1'b1;
            if (pop)     rd_ptr <= rd_ptr + 1'b1;
            count <= count + CW'(push_ok) - CW'(pop);
            if (push && !push_ok) overflow <= 1'b1;
        end
    end

    // Head is presented combinationally and forced to zero while empty.
    assign head    = mem[rd_ptr];
    assign wr_req  = (count != '0);
    assign wr_addr = wr_req ? head[47:36] : 12'd0;
    assign wr_data = wr_req ? head[35:4]  : 32'd0;
    assign wr_be   = wr_req ? head[3:0]   : 4'd0;

`ifdef IPF_WB_STATS_EN
    // Saturating count of words accepted by memory.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            word_cnt <= '0;
        else if (pop && (word_cnt != 16'hFFFF))
            word_cnt <= word_cnt + 16'd1;
    end
`endif

endmodule

// File: tb/tb_ipf_wb_packer.sv
// Directed bench for ipf_wb_packer: a per-cycle vector table for the short
// packing/flush cases plus hand-written overflow, full-FIFO and reset cases.
module tb_ipf_wb_packer;

    localparam int DEPTH = 8;

    logic        clk;
    logic        reset_n;
    logic        in_en;
    logic [7:0]  din;
    logic [13:0] din_addr;
    logic        in_finish;
    logic        wr_req;
    logic [11:0] wr_addr;
    logic [31:0] wr_data;
    logic [3:0]  wr_be;
    logic        wr_ack;
    logic        overflow;
    logic        done;
`ifdef IPF_WB_STATS_EN
    logic [15:0] word_cnt;
`endif

    int n_chk  = 0;
    int n_fail = 0;

    ipf_wb_packer #(.FIFO_DEPTH(DEPTH)) dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .in_en    (in_en),
        .din      (din),
        .din_addr (din_addr),
        .in_finish(in_finish),
        .wr_req   (wr_req),
        .wr_addr  (wr_addr),
        .wr_data  (wr_data),
        .wr_be    (wr_be),
        .wr_ack   (wr_ack),
        .overflow (overflow),
        .done     (done)
`ifdef IPF_WB_STATS_EN
        ,
        .word_cnt (word_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        rst;
        logic        en;
        logic [13:0] addr;
        logic [7:0]  d;
        logic        ack;
        logic        fin;
        logic        ereq;
        logic [11:0] eaddr;
        logic [31:0] edata;
        logic [3:0]  ebe;
        logic        eovf;
        logic        edone;
    } vec_t;

    vec_t tv[$];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic add(input logic rst, input logic en, input logic [13:0] addr,
                       input logic [7:0] d, input logic ack, input logic fin,
                       input logic ereq, input logic [11:0] eaddr, input logic [31:0] edata,
                       input logic [3:0] ebe, input logic eovf, input logic edone);
        vec_t v;
        v.rst = rst; v.en = en; v.addr = addr; v.d = d; v.ack = ack; v.fin = fin;
        v.ereq = ereq; v.eaddr = eaddr; v.edata = edata; v.ebe = ebe;
        v.eovf = eovf; v.edone = edone;
        tv.push_back(v);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset_n = 1'b0; in_en = 1'b0; din = '0; din_addr = '0;
        in_finish = 1'b0; wr_ack = 1'b0;
        #3;
        chk("reset_state", 64'({wr_req, wr_addr, wr_data, wr_be, overflow, done}), 64'd0);
        @(posedge clk);
        #1;
        reset_n = 1'b1;
    endtask

    task automatic pix(input int a, input int d);
        in_en = 1'b1; din_addr = 14'(a); din = 8'(d);
        step();
        in_en = 1'b0;
    endtask

    // Word w of a stream where pixel i (address i) carries data i+1.
    function automatic logic [31:0] word_of(input int w);
        return {8'(4*w+4), 8'(4*w+3), 8'(4*w+2), 8'(4*w+1)};
    endfunction

    // Ack every cycle and compare each head against the stream model.
    task automatic drain(input string name, input int first, input int nexp);
        int n = 0;
        wr_ack = 1'b1;
        for (int c = 0; c < 3 * DEPTH; c++) begin
            if (wr_req) begin
                chk({name, "_addr"}, 64'(wr_addr), 64'(first + n));
                chk({name, "_data"}, 64'(wr_data), 64'(word_of(first + n)));
                chk({name, "_be"},   64'(wr_be),   64'(4'hF));
                n++;
            end
            step();
        end
        wr_ack = 1'b0;
        chk({name, "_nwrites"}, 64'(n), 64'(nexp));
    endtask

    initial begin
        // rst en addr d ack fin | req addr data be ovf done
        // four lanes of one word, ack tied high
        add(1, 1, 14'h0100, 8'h11, 1, 0,  0, 12'h000, 32'h0, 4'h0, 0, 0);
        add(0, 1, 14'h0101, 8'h22, 1, 0,  0, 12'h000, 32'h0, 4'h0, 0, 0);
        add(0, 1, 14'h0102, 8'h33, 1, 0,  0, 12'h000, 32'h0, 4'h0, 0, 0);
        add(0, 1, 14'h0103, 8'h44, 1, 0,  0, 12'h000, 32'h0, 4'h0, 0, 0);
        add(0, 0, 14'h0000, 8'h00, 1, 0,  1, 12'h040, 32'h44332211, 4'hF, 0, 0);
        add(0, 0, 14'h0000, 8'h00, 1, 0,  0, 12'h000, 32'h0, 4'h0, 0, 0);
        add(0, 0, 14'h0000, 8'h00, 1, 1,  0, 12'h000, 32'h0, 4'h0, 0, 0);
        add(0, 0, 14'h0000, 8'h00, 1, 1,  0, 12'h000, 32'h0, 4'h0, 0, 1);
        // two single-lane words, second closed by flush
        add(1, 1, 14'h0005, 8'hA5, 1, 0,  0, 12'h000, 32'h0, 4'h0, 0, 0);
        add(0, 1, 14'h0009, 8'hB9, 1, 0,  1, 12'h001, 32'h0000A500, 4'h2, 0, 0);
        add(0, 0, 14'h0000, 8'h00, 1, 1,  0, 12'h000, 32'h0, 4'h0, 0, 0);
        add(0, 0, 14'h0000, 8'h00, 1, 1,  1, 12'h002, 32'h0000B900, 4'h2, 0, 0);
        add(0, 0, 14'h0000, 8'h00, 1, 1,  0, 12'h000, 32'h0, 4'h0, 0, 0);
        add(0, 0, 14'h0000, 8'h00, 1, 1,  0, 12'h000, 32'h0, 4'h0, 0, 1);
        // lane-3 word then next word; done only after the final ack
        add(1, 1, 14'h0007, 8'h77, 0, 0,  0, 12'h000, 32'h0, 4'h0, 0, 0);
        add(0, 1, 14'h0008, 8'h88, 0, 0,  1, 12'h001, 32'h77000000, 4'h8, 0, 0);
        add(0, 0, 14'h0000, 8'h00, 0, 1,  1, 12'h001, 32'h77000000, 4'h8, 0, 0);
        add(0, 0, 14'h0000, 8'h00, 0, 1,  1, 12'h001, 32'h77000000, 4'h8, 0, 0);
        add(0, 0, 14'h0000, 8'h00, 1, 1,  1, 12'h002, 32'h00000088, 4'h1, 0, 0);
        add(0, 0, 14'h0000, 8'h00, 0, 1,  1, 12'h002, 32'h00000088, 4'h1, 0, 0);
        add(0, 0, 14'h0000, 8'h00, 1, 1,  0, 12'h000, 32'h0, 4'h0, 0, 0);
        add(0, 0, 14'h0000, 8'h00, 0, 1,  0, 12'h000, 32'h0, 4'h0, 0, 1);

        for (int i = 0; i < tv.size(); i++) begin
            if (tv[i].rst) do_reset();
            in_en = tv[i].en; din_addr = tv[i].addr; din = tv[i].d;
            wr_ack = tv[i].ack; in_finish = tv[i].fin;
            step();
            chk($sformatf("vec%0d", i),
                64'({wr_req, wr_addr, wr_data, wr_be, overflow, done}),
                64'({tv[i].ereq, tv[i].eaddr, tv[i].edata, tv[i].ebe, tv[i].eovf, tv[i].edone}));
        end

        // Overflow: no acks while 4*(DEPTH+1) pixels stream in.
        do_reset();
        for (int i = 0; i < 4 * (DEPTH + 1); i++) begin
            chk("ovf_early", 64'(overflow), 64'd0);
            pix(i, i + 1);
        end
        step();
        chk("ovf_flag", 64'(overflow), 64'd1);
        chk("ovf_head", 64'(wr_addr), 64'd0);
        drain("ovf_drain", 0, DEPTH);
        chk("ovf_sticky", 64'(overflow), 64'd1);
`ifdef IPF_WB_STATS_EN
        chk("ovf_word_cnt", 64'(word_cnt), 64'(DEPTH));
`endif

        // Full FIFO with a pop on the same edge as a push: nothing dropped.
        do_reset();
        for (int i = 0; i < 4 * (DEPTH + 1); i++) pix(i, i + 1);
        wr_ack = 1'b1;
        step();
        wr_ack = 1'b0;
        chk("full_pp_ovf", 64'(overflow), 64'd0);
        chk("full_pp_head", 64'(wr_addr), 64'd1);
        drain("full_pp_drain", 1, DEPTH);
        chk("full_pp_ovf_end", 64'(overflow), 64'd0);

        // Reset mid-stream with three words queued.
        do_reset();
        for (int i = 0; i < 13; i++) pix(i, i + 1);
        chk("rst_pre_req", 64'(wr_req), 64'd1);
        #2;
        reset_n = 1'b0;
        #1;
        chk("rst_async", 64'({wr_req, wr_addr, wr_data, wr_be, overflow, done}), 64'd0);
        step();
        reset_n = 1'b1;
        wr_ack = 1'b1;
        for (int c = 0; c < 10; c++) begin
            step();
            chk("rst_post_req", 64'(wr_req), 64'd0);
        end
        chk("rst_post_done", 64'(done), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
